iig_buf: RTL
============

IIG_BUF -- requirements
Module: iig_buf

Interface
REQ-001 Parameter LINE_LEN, default 320: integral values per image row; depth of the line store.
REQ-002 Parameter NUM_ROWS, default 240: rows per frame.
REQ-003 Parameter DATA_W, default 21: width of one integral value.
REQ-004 iClk  input  1  the single clock; all state changes on its rising edge.
REQ-005 iReset  input  1  synchronous, active-high reset.
REQ-006 iStart  input  1  one-cycle frame-start pulse.
REQ-007 iRd  input  1  read strobe: fetch the previous-row value for the next column.
REQ-008 iWr  input  1  write strobe: store the current-row integral value from the sum stage.
REQ-009 iData  input  DATA_W  integral value to store.
REQ-010 oData  output  DATA_W  previous-row integral value; feeds the sum stage's BUF0 input.
REQ-011 oValid  output  1  oData valid this cycle.
REQ-012 oEnable  output  1  high when oData is a real previous-row value (row > 0); drives the sum stage's enable.
REQ-013 oRow_done  output  1  one-cycle pulse after the last column read of a row.
REQ-014 oFrame_done  output  1  one-cycle pulse after the last column read of the last row.

Function
REQ-015 The block SHALL keep independent read and write column pointers, each 0..LINE_LEN-1.
- Each pointer advances by one on its own strobe.
- Each pointer wraps from LINE_LEN-1 to 0.
REQ-016 The block SHALL keep a row counter 0..NUM_ROWS-1.
- The counter increments when the read pointer wraps.
- It wraps to 0 at NUM_ROWS-1.
REQ-017 Read latency SHALL be exactly 1 cycle: an iRd in cycle n gives oData/oValid/oEnable in cycle n+1.
REQ-018 Output values for a read in row 0:
- oData SHALL be 0 and oEnable 0.
- The store SHALL still be addressed, but its content SHALL be ignored.
REQ-019 For a read in rows 1..NUM_ROWS-1:
- oData SHALL equal the value written at the same column in the previous row.
- oEnable SHALL be 1.
REQ-020 With iRd and iWr in the same cycle at the same address, the read SHALL return the old content (read-before-write).
REQ-021 oValid SHALL be 0 in any cycle not following an iRd.
- oData SHALL hold its last value when oValid is 0.
REQ-022 oRow_done SHALL pulse in the same cycle as the oValid of the column LINE_LEN-1 read.
REQ-023 oFrame_done SHALL pulse with oRow_done when that row is NUM_ROWS-1.
REQ-024 iStart SHALL clear both pointers and the row counter.
- An iRd/iWr in the same cycle as iStart SHALL act as column 0, row 0 of the new frame.
REQ-025 Stored data SHALL be passed through unmodified; there is no arithmetic on data.

Reset
REQ-026 While iReset is high:
- oData, oValid, oEnable, oRow_done and oFrame_done SHALL be 0.
- Pointers and the row counter SHALL be 0.
- iStart, iRd and iWr SHALL be ignored.
REQ-027 Reset SHALL dominate iStart and abort any frame in progress.
REQ-028 Line-store contents are undefined after reset; REQ-018 masks them.

Configuration
REQ-029 Macro IIG_BUF_ERR_CHK_EN: when defined, the block SHALL add an output oErr (1 bit, sticky).
- It SHALL keep an occupancy count: +1 on iWr, -1 on an iRd in rows > 0.
- oErr SHALL set on iWr at occupancy LINE_LEN (overrun).
- oErr SHALL set on an iRd in a row > 0 at occupancy 0 (underrun).
- The occupancy count and oErr SHALL clear on reset or iStart.
REQ-030 When the macro is undefined, there SHALL be no oErr port and no occupancy logic; all other behaviour is identical.

Structure
REQ-031 A shared package SHALL hold:
- DATA_W default;
- LINE_LEN and NUM_ROWS defaults;
- the pointer-width computation (clog2 of LINE_LEN).
REQ-032 One sub-module, iig_line_ram, SHALL provide the store:
- dual-port, one write port and one registered read-first read port;
- depth LINE_LEN, width DATA_W.

Verification (LINE_LEN=4, NUM_ROWS=3)
REQ-033 Row 0: iStart, then 4 iRd each paired with iWr of 10,20,30,40 -> oData=0, oEnable=0, oValid one cycle after each iRd, oRow_done with the 4th.
REQ-034 Row 1: 4 iRd/iWr, writes 11,22,33,44 -> oData=10,20,30,40, oEnable=1.
REQ-035 Row 2 reads -> 11,22,33,44; oFrame_done and oRow_done pulse together with the 4th; the next read returns to row 0 (oEnable=0).
REQ-036 iReset asserted mid row 1, then iStart -> all outputs 0 during reset; the next read gives oEnable=0, oData=0.
REQ-037 With IIG_BUF_ERR_CHK_EN: 5 iWr without iRd in row 1 -> oErr=1 after the 5th, held until iStart.
REQ-038 Gapped strobes (iRd every third cycle) -> same data sequence as REQ-034; oValid only following each iRd.

Source files
------------

// File: rtl/iig_buf_pkg.sv
// Shared defaults and sizing helpers for the integral-image line buffer.
package iig_buf_pkg;

  localparam int unsigned DATA_W_DEF   = 21;
  localparam int unsigned LINE_LEN_DEF = 320;
  localparam int unsigned NUM_ROWS_DEF = 240;

  // Address width needed to index n entries; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iig_line_ram.sv
// One-row line store: single write port plus a registered read-first read port.
module iig_line_ram
  import iig_buf_pkg::*;
#(
  parameter int unsigned DEPTH = LINE_LEN_DEF,
  parameter int unsigned WIDTH = DATA_W_DEF,
  parameter int unsigned AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  // A read captures the old word; without a read the output register holds.
  always_comb begin
    rd_data_d = rd_data_q;
    if (re) rd_data_d = mem[raddr];
  end

  // Storage array and read register; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data_q <= rd_data_d;
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/iig_buf.sv
// Integral-image previous-row line buffer with independent read/write columns.
// Optional macro IIG_BUF_ERR_CHK_EN adds a sticky overrun/underrun flag oErr.
module iig_buf
  import iig_buf_pkg::*;
#(
  parameter int unsigned LINE_LEN = LINE_LEN_DEF,
  parameter int unsigned NUM_ROWS = NUM_ROWS_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iStart,
  input  logic              iRd,
  input  logic              iWr,
  input  logic [DATA_W-1:0] iData,
  output logic [DATA_W-1:0] oData,
  output logic              oValid,
  output logic              oEnable,
  output logic              oRow_done,
  output logic              oFrame_done
`ifdef IIG_BUF_ERR_CHK_EN
  ,
  output logic              oErr
`endif
);

  localparam int unsigned PTR_W = ptr_w(LINE_LEN);
  localparam int unsigned ROW_W = ptr_w(NUM_ROWS);
  localparam logic [PTR_W-1:0] LAST_COL = PTR_W'(LINE_LEN - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, rd_base;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_base;
  logic [ROW_W-1:0] row_q, row_d, row_base;
  logic             valid_q, valid_d;
  logic             enable_q, enable_d;
  logic             row_done_q, row_done_d;
  logic             frame_done_q, frame_done_d;
  logic             rd_en, wr_en, start_en, rd_last, row_last;
  logic [DATA_W-1:0] ram_rdata;

  // Strobes are ignored under reset; a start rebases pointers so same-cycle strobes hit column 0, row 0.
  always_comb begin
    rd_en    = iRd & ~iReset;
    wr_en    = iWr & ~iReset;
    start_en = iStart & ~iReset;
    rd_base  = start_en ? '0 : rd_ptr_q;
    wr_base  = start_en ? '0 : wr_ptr_q;
    row_base = start_en ? '0 : row_q;
    rd_last  = (rd_base == LAST_COL);
    row_last = (row_base == LAST_ROW);

    rd_ptr_d = rd_base;
    row_d    = row_base;
    if (rd_en) begin
      rd_ptr_d = rd_last ? '0 : rd_base + 1'b1;
      if (rd_last) row_d = row_last ? '0 : row_base + 1'b1;
    end

    wr_ptr_d = wr_base;
    if (wr_en) wr_ptr_d = (wr_base == LAST_COL) ? '0 : wr_base + 1'b1;

    valid_d      = rd_en;
    row_done_d   = rd_en & rd_last;
    frame_done_d = rd_en & rd_last & row_last;
    enable_d     = rd_en ? (row_base != '0) : enable_q;
  end

  // Pointer, row and output-flag registers.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      row_q        <= '0;
      valid_q      <= 1'b0;
      enable_q     <= 1'b0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      row_q        <= row_d;
      valid_q      <= valid_d;
      enable_q     <= enable_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  iig_line_ram #(
    .DEPTH (LINE_LEN),
    .WIDTH (DATA_W),
    .AW    (PTR_W)
  ) u_ram (
    .clk   (iClk),
    .we    (wr_en),
    .waddr (wr_base),
    .wdata (iData),
    .re    (rd_en),
    .raddr (rd_base),
    .rdata (ram_rdata)
  );

  // Row-0 reads still address the store but their content is masked to zero.
  assign oData       = enable_q ? ram_rdata : '0;
  assign oValid      = valid_q;
  assign oEnable     = enable_q;
  assign oRow_done   = row_done_q;
  assign oFrame_done = frame_done_q;

`ifdef IIG_BUF_ERR_CHK_EN
  localparam int unsigned OCC_W = ptr_w(LINE_LEN + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(LINE_LEN);

  logic [OCC_W-1:0] occ_q, occ_d, occ_base;
  logic             err_q, err_d, rd_consume;

  // Occupancy grows on writes and shrinks on real previous-row reads; saturating edges raise the sticky flag.
  always_comb begin
    occ_base   = start_en ? '0 : occ_q;
    err_d      = start_en ? 1'b0 : err_q;
    rd_consume = rd_en & (row_base != '0);
    occ_d      = occ_base;
    if ((wr_en && occ_base == OCC_FULL) || (rd_consume && occ_base == '0)) err_d = 1'b1;
    case ({wr_en, rd_consume})
      2'b10:   if (occ_base != OCC_FULL) occ_d = occ_base + 1'b1;
      2'b01:   if (occ_base != '0) occ_d = occ_base - 1'b1;
      default: occ_d = occ_base;
    endcase
  end

  // Occupancy and error registers.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      err_q <= err_d;
    end
  end

  assign oErr = err_q;
`endif

endmodule
